fxp_div: RTL



---
 rtl/fxp_div.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fxp_div.sv
// fxp_div: signed Q15.16 restoring divider, 1 quotient bit/clk, round-half-away, saturating, divide-by-zero flag; ports clk, rst_n, start, a, b -> busy, done, quot, sat, dbz
module fxp_div #(
  parameter int NB_DATA  = 32,
  parameter int NBF_DATA = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NB_DATA-1:0] a,
  input  logic [NB_DATA-1:0] b,
  output logic               busy,
  output logic               done,
  output logic [NB_DATA-1:0] quot,
  output logic               sat,
  output logic               dbz
);
  localparam int NB_MAG = NB_DATA + 1;
  localparam int NB_DQ  = NB_DATA + NBF_DATA + 1;
  localparam int STEPS  = NB_DQ;
  localparam logic [NB_DATA-1:0] MAX_POS = {1'b0, {(NB_DATA-1){1'b1}}};
  localparam logic [NB_DATA-1:0] MIN_NEG = {1'b1, {(NB_DATA-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [NB_MAG-1:0]   rem_q, rem_d, mb_q, mb_d;
  logic [NB_DQ-1:0]    dq_q, dq_d;
  logic                sign_q, sign_d, a_neg_q, a_neg_d, bz_q, bz_d;
  logic                busy_q, busy_d, done_q, done_d, sat_q, sat_d, dbz_q, dbz_d;
  logic [NB_DATA-1:0]  quot_q, quot_d;
  logic [NB_MAG-1:0]   ax, bx, ma, mb;
  logic [NB_MAG:0]     rem_sh;
  logic                ge;
  logic [NB_DQ-1:0]    m;
  assign ax = {a[NB_DATA-1], a};
  assign bx = {b[NB_DATA-1], b};
  // 33-bit magnitudes so |0x80000000| = 2^31 is representable
  assign ma = a[NB_DATA-1] ? -ax : ax;
  assign mb = b[NB_DATA-1] ? -bx : bx;
  // dq_q holds the unconsumed dividend bits in its top and collects quotient bits at its bottom
  assign rem_sh = {rem_q, dq_q[NB_DQ-1]};
  assign ge     = rem_sh >= {1'b0, mb_q};
  assign m      = NB_DQ'(({1'b0, dq_q} + 1'b1) >> 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    mb_d    = mb_q;
    dq_d    = dq_q;
    sign_d  = sign_q;
    a_neg_d = a_neg_q;
    bz_d    = bz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    sat_d   = sat_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = CALC;
        busy_d  = 1'b1;
        cnt_d   = '0;
        rem_d   = '0;
        mb_d    = mb;
        dq_d    = NB_DQ'(ma) << (NBF_DATA + 1);
        sign_d  = a[NB_DATA-1] ^ b[NB_DATA-1];
        a_neg_d = a[NB_DATA-1];
        bz_d    = b == '0;
      end
      CALC: begin
        rem_d   = ge ? NB_MAG'(rem_sh - {1'b0, mb_q}) : rem_sh[NB_MAG-1:0];
        dq_d    = {dq_q[NB_DQ-2:0], ge};
        cnt_d   = cnt_q + 6'd1;
        state_d = cnt_q == 6'(STEPS - 1) ? FIN : CALC;
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dbz_d   = bz_q;
        if (bz_q) begin
          quot_d = a_neg_q ? MIN_NEG : MAX_POS;
          sat_d  = 1'b1;
        end else if (!sign_q && m > NB_DQ'(MAX_POS)) begin
          quot_d = MAX_POS;
          sat_d  = 1'b1;
        end else if (sign_q && m > NB_DQ'(MIN_NEG)) begin
          quot_d = MIN_NEG;
          sat_d  = 1'b1;
        end else begin
          quot_d = sign_q ? -m[NB_DATA-1:0] : m[NB_DATA-1:0];
          sat_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      mb_q    <= '0;
      dq_q    <= '0;
      sign_q  <= 1'b0;
      a_neg_q <= 1'b0;
      bz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      sat_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      mb_q    <= mb_d;
      dq_q    <= dq_d;
      sign_q  <= sign_d;
      a_neg_q <= a_neg_d;
      bz_q    <= bz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      sat_q   <= sat_d;
      dbz_q   <= dbz_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign quot = quot_q;
  assign sat  = sat_q;
  assign dbz  = dbz_q;
endmodule
